// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// Outgoing side of one front-side-bus hop.
// Pass-through bus words always win the next segment. Local words wait in a
// small FIFO and use only idle bus slots. A saturating wait counter flags a
// local head word that has been blocked for too long.
module bsg_front_side_bus_hop_out_no_fc #(
    parameter int width_p         = 32,
    parameter int els_p           = 2,
    parameter int starve_thresh_p = 15
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               bus_v_i,
    input  logic [width_p-1:0] bus_data_i,
    input  logic               local_v_i,
    input  logic [width_p-1:0] local_data_i,
    output logic               local_ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               starved_o
);

    localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp  = $clog2(els_p + 1);
    localparam int wait_w_lp = $clog2(starve_thresh_p + 1);

    localparam logic [ptr_w_lp-1:0]  last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [cnt_w_lp-1:0]  els_cnt_lp  = cnt_w_lp'(els_p);
    localparam logic [wait_w_lp-1:0] thresh_lp   = wait_w_lp'(starve_thresh_p);

    // Injection FIFO storage; entries are not reset (contents are only
    // meaningful while counted).
    logic [width_p-1:0]   mem_reg [els_p];

    logic [ptr_w_lp-1:0]  wptr_reg, wptr_next;
    logic [ptr_w_lp-1:0]  rptr_reg, rptr_next;
    logic [cnt_w_lp-1:0]  count_reg, count_next;
    logic [wait_w_lp-1:0] wait_cnt_reg, wait_cnt_next;
    logic                 starved_reg, starved_next;
    logic                 v_reg, v_next;
    logic [width_p-1:0]   data_reg, data_next;

    logic enq, deq, not_empty;

    // Ready depends only on the registered occupancy, so a same-cycle
    // dequeue never admits a word into a full FIFO.
    assign local_ready_o = (count_reg < els_cnt_lp);
    assign v_o           = v_reg;
    assign data_o        = data_reg;
    assign starved_o     = starved_reg;

    // Arbitration, FIFO bookkeeping and starvation counting for this cycle.
    always_comb begin
        not_empty = (count_reg != '0);
        enq       = local_v_i & local_ready_o;
        deq       = ~bus_v_i & not_empty;

        count_next = count_reg;
        if (enq && !deq) begin
            count_next = count_reg + cnt_w_lp'(1);
        end else if (deq && !enq) begin
            count_next = count_reg - cnt_w_lp'(1);
        end

        wptr_next = wptr_reg;
        if (enq) begin
            wptr_next = (wptr_reg == last_ptr_lp) ? '0 : wptr_reg + ptr_w_lp'(1);
        end

        rptr_next = rptr_reg;
        if (deq) begin
            rptr_next = (rptr_reg == last_ptr_lp) ? '0 : rptr_reg + ptr_w_lp'(1);
        end

        // Bus has strict priority; the FIFO head fills otherwise idle slots.
        v_next    = bus_v_i | not_empty;
        data_next = bus_v_i ? bus_data_i : mem_reg[rptr_reg];

        // Count only cycles where a queued word is pushed aside by the bus;
        // a dequeue or an empty FIFO both mean nothing is being starved.
        wait_cnt_next = '0;
        if (not_empty && bus_v_i) begin
            wait_cnt_next = (wait_cnt_reg == thresh_lp) ? thresh_lp
                                                        : wait_cnt_reg + wait_w_lp'(1);
        end
        starved_next = (wait_cnt_next == thresh_lp);
    end

    // Control state: pointers, occupancy, output valid and starvation flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            wait_cnt_reg <= '0;
            starved_reg  <= 1'b0;
            v_reg        <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            wait_cnt_reg <= wait_cnt_next;
            starved_reg  <= starved_next;
            v_reg        <= v_next;
        end
    end

    // Output word register; left unreset since it is ignored while v_o is low.
    always_ff @(posedge clk_i) begin
        data_reg <= data_next;
    end

    // One write-enabled register per FIFO entry, selected by the write pointer.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (!reset_i && enq && (wptr_reg == ptr_w_lp'(gi))) begin
                mem_reg[gi] <= local_data_i;
            end
        end
    end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
// Self-checking bench for bsg_front_side_bus_hop_out_no_fc: directed scenarios
// followed by randomized traffic, all compared against a queue-based model.
module tb_bsg_front_side_bus_hop_out_no_fc;

    localparam int W = 32;
    localparam int ELS = 2;
    localparam int T = 15;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         bus_v_i = 1'b0;
    logic [W-1:0] bus_data_i = '0;
    logic         local_v_i = 1'b0;
    logic [W-1:0] local_data_i = '0;
    logic         local_ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         starved_o;

    bsg_front_side_bus_hop_out_no_fc #(
        .width_p(W), .els_p(ELS), .starve_thresh_p(T)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .bus_v_i(bus_v_i), .bus_data_i(bus_data_i),
        .local_v_i(local_v_i), .local_data_i(local_data_i),
        .local_ready_o(local_ready_o),
        .v_o(v_o), .data_o(data_o), .starved_o(starved_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit verbose  = 1'b1;

    // Reference model state
    logic [W-1:0] q[$];
    logic         exp_v = 1'b0;
    logic [W-1:0] exp_d = '0;
    int           wait_n = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs (entered just after a negedge), check
    // ready, advance the model at the edge, then check registered outputs.
    task automatic step(input logic rst, input logic bv, input logic [W-1:0] bd,
                        input logic lv, input logic [W-1:0] ld, output bit accepted);
        bit pre_ready;
        reset_i = rst; bus_v_i = bv; bus_data_i = bd; local_v_i = lv; local_data_i = ld;
        pre_ready = (q.size() < ELS);
        #1;
        check("local_ready", {31'b0, local_ready_o}, {31'b0, pre_ready});
        @(posedge clk_i);
        accepted = 1'b0;
        if (rst) begin
            q.delete();
            exp_v = 1'b0;
            wait_n = 0;
        end else begin
            if (q.size() > 0 && bv) wait_n = (wait_n < T) ? wait_n + 1 : T;
            else wait_n = 0;
            if (bv) begin
                exp_v = 1'b1; exp_d = bd;
            end else if (q.size() > 0) begin
                exp_v = 1'b1; exp_d = q.pop_front();
            end else begin
                exp_v = 1'b0;
            end
            if (lv && pre_ready) begin
                q.push_back(ld);
                accepted = 1'b1;
            end
        end
        @(negedge clk_i);
        check("v_o", {31'b0, v_o}, {31'b0, exp_v});
        if (exp_v) check("data_o", data_o, exp_d);
        check("starved_o", {31'b0, starved_o}, {31'b0, (wait_n == T)});
        if (verbose)
            $display("t=%0t rst=%0b bus=%0b/%h loc=%0b/%h acc=%0b -> v=%0b d=%h starved=%0b",
                     $time, rst, bv, bd, lv, ld, accepted, v_o, data_o, starved_o);
    endtask

    logic         hold_v;
    logic [W-1:0] hold_d;

    // Local-side driver that holds an unaccepted word, as the local node must.
    task automatic step_hold(input logic rst, input logic bv, input logic [W-1:0] bd);
        bit acc;
        step(rst, bv, bd, hold_v, hold_d, acc);
        if (acc || rst) hold_v = 1'b0;
    endtask

    initial begin
        bit acc;
        // First reset cycle: outputs unknown before the edge, check after it.
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_v", {31'b0, v_o}, 32'd0);
        check("rst_starved", {31'b0, starved_o}, 32'd0);
        step(1'b1, 1'b0, '0, 1'b0, '0, acc);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0, acc);

        // Bus only
        step(1'b0, 1'b1, 32'h11, 1'b0, '0, acc);
        step(1'b0, 1'b1, 32'h22, 1'b0, '0, acc);
        step(1'b0, 1'b1, 32'h33, 1'b0, '0, acc);
        step(1'b0, 1'b0, '0, 1'b0, '0, acc);

        // Local only: 2-cycle latency, then back-to-back words in order
        step(1'b0, 1'b0, '0, 1'b1, 32'hA5A5A5A5, acc);
        check("a5_no_bypass", {31'b0, v_o}, 32'd0);
        step(1'b0, 1'b0, '0, 1'b0, '0, acc);
        check("a5_at_t2", data_o, 32'hA5A5A5A5);
        step(1'b0, 1'b0, '0, 1'b1, 32'h1, acc);
        step(1'b0, 1'b0, '0, 1'b1, 32'h2, acc);
        step(1'b0, 1'b0, '0, 1'b1, 32'h3, acc);
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0, acc);

        // Full / backpressure under continuous bus traffic
        hold_v = 1'b1; hold_d = 32'hB0; step_hold(1'b0, 1'b1, 32'hC0);
        hold_v = 1'b1; hold_d = 32'hB1; step_hold(1'b0, 1'b1, 32'hC1);
        hold_v = 1'b1; hold_d = 32'hB2;
        for (int i = 0; i < 3; i++) step_hold(1'b0, 1'b1, 32'hC2 + W'(i));
        check("b2_held", {31'b0, hold_v}, 32'd1);
        for (int i = 0; i < 5; i++) step_hold(1'b0, 1'b0, '0);

        // Starvation: one queued word blocked by 20 bus cycles
        step(1'b0, 1'b1, 32'hD0, 1'b1, 32'h5A, acc);
        for (int i = 1; i < 20; i++) step(1'b0, 1'b1, 32'hD0 + W'(i), 1'b0, '0, acc);
        check("starved_hi", {31'b0, starved_o}, 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, '0, acc);
        check("starved_lo", {31'b0, starved_o}, 32'd0);
        check("starve_word", data_o, 32'h5A);
        step(1'b0, 1'b0, '0, 1'b0, '0, acc);

        // Reset mid-operation with two queued words
        step(1'b0, 1'b1, 32'hE0, 1'b1, 32'hF0, acc);
        step(1'b0, 1'b1, 32'hE1, 1'b1, 32'hF1, acc);
        step(1'b1, 1'b0, '0, 1'b0, '0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, '0, acc);

        // Randomized traffic with phases of heavy and light bus load
        verbose = 1'b0;
        hold_v = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int busy_pct;
            logic bv, rst;
            busy_pct = ((i / 250) % 3 == 0) ? 95 : (((i / 250) % 3 == 1) ? 50 : 15);
            bv  = ($urandom_range(0, 99) < busy_pct);
            rst = ($urandom_range(0, 299) == 0);
            if (!hold_v && $urandom_range(0, 1) == 1) begin
                hold_v = 1'b1;
                hold_d = $urandom;
            end
            step_hold(rst, bv, $urandom);
        end
        // Drain
        for (int i = 0; i < 6; i++) step_hold(1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bsg_front_side_bus_hop_out_no_fc.md
Name: bsg_front_side_bus_hop_out_no_fc

Overview:
Outgoing-side arbiter for one front-side-bus hop. It merges the pass-through bus stream with traffic injected by the local node onto the next bus segment. The bus has no flow control, so pass-through traffic always has strict priority. Local traffic waits in a small FIFO and takes only idle bus slots. A saturating wait counter flags local starvation to software/debug.

Parameters:
width_p, 32, bus word width in bits
els_p, 2, local injection FIFO depth in entries (>=2)
starve_thresh_p, 15, consecutive blocked cycles before starved_o asserts (>=1)

Ports:
clk_i  input  1  clock; all state updates on posedge
reset_i  input  1  synchronous, active-high reset
bus_v_i  input  1  pass-through word valid from upstream hop (no flow control, never stalled)
bus_data_i  input  width_p  pass-through word
local_v_i  input  1  local node injection valid
local_data_i  input  width_p  local injection word
local_ready_o  output  1  local FIFO can accept a word this cycle
v_o  output  1  outgoing segment word valid (registered)
data_o  output  width_p  outgoing segment word (registered)
starved_o  output  1  local head has been blocked starve_thresh_p consecutive cycles

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Reset state: v_o=0, FIFO empty (count=0, pointers=0), wait_cnt=0, starved_o=0, local_ready_o=1 in the first cycle after reset deasserts. data_o is not reset and is don't-care while v_o=0.
- local_ready_o = (count < els_p). It is a function of registered count only and does not depend on a same-cycle dequeue.
- Enqueue: local_v_i & local_ready_o. The word is written at wptr, and wptr wraps modulo els_p.
- Arbitration (combinational per cycle):
  - If bus_v_i=1: bus wins. Next data_o=bus_data_i and v_o=1.
  - Else if count>0: FIFO head dequeues. Next data_o=head and v_o=1. rptr wraps modulo els_p.
  - Else: v_o=0 next cycle.
- Latency:
  - Bus to output: 1 cycle.
  - Local to output: minimum 2 cycles. A word enqueued in cycle t is eligible for dequeue in cycle t+1 and appears on v_o/data_o at t+2. No bypass of an empty FIFO.
- Simultaneous enqueue and dequeue: legal when count<els_p. Count is unchanged and ordering is preserved (FIFO order strictly kept).
- Full: local_ready_o=0. The local node must hold local_v_i/local_data_i. A dequeue in that cycle does not admit a word until the next cycle.
- Wait counter (width $clog2(starve_thresh_p+1)):
  - Increments when count>0 & bus_v_i, saturating at starve_thresh_p.
  - Clears to 0 on any dequeue, or when count==0.
  - starved_o = (wait_cnt == starve_thresh_p), registered. It deasserts the cycle after the dequeue that clears the counter.
- Bus words are never dropped or delayed beyond 1 cycle. Local words are never dropped.
- reset_i asserted mid-operation: all FIFO contents discarded, v_o=0 next cycle, counter cleared. Inputs during reset are ignored.

Test Plan:
- Reset then idle: reset_i=1 for 2 cycles, all inputs 0 -> v_o=0, local_ready_o=1, starved_o=0 every cycle.
- Bus only: bus_v_i=1 with data 0x11,0x22,0x33 on consecutive cycles -> v_o=1 and data_o=0x11,0x22,0x33 one cycle later, FIFO untouched.
- Local only, bus idle: local word 0xA5A5A5A5 enqueued at cycle t -> v_o=1 with data_o=0xA5A5A5A5 at t+2 exactly. Back-to-back 0x1,0x2,0x3 emerge in order on consecutive cycles.
- Full/backpressure: bus_v_i=1 continuously; enqueue 0xB0,0xB1 -> local_ready_o=0 after the second. A held 0xB2 is not accepted. When bus_v_i drops, output is 0xB0,0xB1,0xB2 in order and 0xB2 is accepted the cycle after the first dequeue.
- Starvation: one local word queued, bus_v_i=1 for 20 cycles -> starved_o rises once wait_cnt reaches 15 (holds saturated). When bus goes idle, the word dequeues and starved_o=0 the following cycle.
- Reset mid-operation: FIFO holding 2 words, reset_i pulsed 1 cycle -> v_o=0 after reset and stays 0 with bus idle (queued words discarded), local_ready_o=1, starved_o=0.
